// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - round-robin arbiter sharing one cache lookup port
module cache_port_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = 32,
  parameter int ID_W         = 2,
  parameter int MISS_PENALTY = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cache_valid,
  output logic [ADDR_W-1:0]         cache_addr,
  input  logic                      cache_hit,
  input  logic                      cache_miss,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic                      resp_hit,
  output logic                      busy,
  output logic                      err,
  input  logic [ID_W-1:0]           stat_sel,
  output logic [31:0]               stat_hits,
  output logic [31:0]               stat_misses
);

  localparam int SW = (MISS_PENALTY > 0) ? $clog2(MISS_PENALTY + 1) : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP, STALL} state_t;

  state_t                    state, state_nxt;
  logic [ID_W-1:0]           rr_ptr;
  logic [ID_W-1:0]           cur_id;
  logic [ID_W-1:0]           grant_id;
  logic [ID_W-1:0]           cand;
  logic                      grant_any;
  logic                      grant_fire;
  logic [SW-1:0]             stall_cnt;
  logic [ADDR_W-1:0]         addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0][31:0]  hit_cnt;
  logic [NUM_REQ-1:0][31:0]  miss_cnt;
  logic                      is_hit;
  logic                      proto_err;
  logic                      fire;
  logic                      fire_hit;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Search upward from rr_ptr with wrap; first pending requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign grant_fire = rst && (state == IDLE) && grant_any;
  assign req_ready  = grant_fire ? (NUM_REQ'(1) << grant_id) : '0;
  assign busy       = (state != IDLE);

  // A malformed cache answer (both or neither) is treated as a miss.
  assign is_hit    = cache_hit && !cache_miss;
  assign proto_err = (cache_hit == cache_miss);
  assign fire      = ((state == RESP) && (is_hit || (MISS_PENALTY == 0))) ||
                     ((state == STALL) && (stall_cnt == SW'(1)));
  assign fire_hit  = (state == RESP) && is_hit;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = RESP;
      RESP:    state_nxt = (is_hit || (MISS_PENALTY == 0)) ? IDLE : STALL;
      STALL:   if (stall_cnt == SW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cur_id      <= '0;
      stall_cnt   <= '0;
      cache_valid <= 1'b0;
      cache_addr  <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_hit    <= 1'b0;
      err         <= 1'b0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      cache_valid <= 1'b0;
      resp_valid  <= 1'b0;
      if (grant_fire) begin
        cur_id      <= grant_id;
        cache_addr  <= addr_arr[grant_id];
        cache_valid <= 1'b1;
        rr_ptr      <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
      if (state == RESP) begin
        stall_cnt <= SW'(MISS_PENALTY);
        if (proto_err) err <= 1'b1;
      end
      if (state == STALL) stall_cnt <= stall_cnt - 1'b1;
      if (fire) begin
        resp_valid <= 1'b1;
        resp_id    <= cur_id;
        resp_hit   <= fire_hit;
        if (fire_hit) begin
          if (hit_cnt[cur_id] != '1) hit_cnt[cur_id] <= hit_cnt[cur_id] + 32'd1;
        end else begin
          if (miss_cnt[cur_id] != '1) miss_cnt[cur_id] <= miss_cnt[cur_id] + 32'd1;
        end
      end
    end
  end

  assign stat_hits   = hit_cnt[stat_sel];
  assign stat_misses = miss_cnt[stat_sel];

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - scoreboard bench for cache_port_arbiter
module tb_cache_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int IW = 2;
  localparam int P  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic            cache_valid;
  logic [AW-1:0]   cache_addr;
  logic            cache_hit, cache_miss;
  logic            resp_valid;
  logic [IW-1:0]   resp_id;
  logic            resp_hit;
  logic            busy, err;
  logic [IW-1:0]   stat_sel;
  logic [31:0]     stat_hits, stat_misses;

  cache_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .ID_W(IW), .MISS_PENALTY(P)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .cache_valid(cache_valid), .cache_addr(cache_addr), .cache_hit(cache_hit),
    .cache_miss(cache_miss), .resp_valid(resp_valid), .resp_id(resp_id), .resp_hit(resp_hit),
    .busy(busy), .err(err), .stat_sel(stat_sel), .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            at;
    logic [AW-1:0] addr;
    int            id;
    bit            hit;
    bit            miss;
  } ev_t;

  ev_t           look_q[$];
  ev_t           resp_q[$];
  ev_t           cache_q[$];
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;
  int            m_ptr, m_free, m_gnt, err_at;
  logic [31:0]   m_hits[N];
  logic [31:0]   m_miss[N];
  logic [AW-1:0] addr_hold[N];
  int            mode;
  int            fix_sel;
  logic [N-1:0]  pending;
  bit            ev_l, ev_r;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: one lookup at a time; a grant at T answers at T+3 (hit) or T+3+P (miss).
  task automatic issue(input int g);
    bit h, m;
    int r, lat;
    case (mode)
      0: begin h = 1; m = 0; end
      1: begin h = 0; m = 1; end
      2: begin h = 1; m = 1; end
      3: begin h = 0; m = 0; end
      default: begin
        r = $urandom_range(0, 9);
        h = (r < 5) || (r == 8);
        m = (r >= 5) && (r != 9);
      end
    endcase
    lat = (h && !m) ? 3 : 3 + P;
    cache_q.push_back('{at: cyc + 2, addr: '0, id: g, hit: h, miss: m});
    look_q.push_back('{at: cyc + 1, addr: addr_hold[g], id: g, hit: 1'b0, miss: 1'b0});
    resp_q.push_back('{at: cyc + lat, addr: '0, id: g, hit: (h && !m), miss: 1'b0});
    if (h == m && err_at > cyc + 3) err_at = cyc + 3;
    m_gnt  = cyc;
    m_free = cyc + lat;
    m_ptr  = (g + 1) % N;
  endtask

  task automatic tick(input logic [N-1:0] v);
    logic [N-1:0] er;
    int g;
    @(negedge clk);
    req_valid = v;
    for (int k = 0; k < N; k++) req_addr[k*AW +: AW] = addr_hold[k];
    if (cache_q.size() > 0 && cache_q[0].at == cyc) begin
      cache_hit  = cache_q[0].hit;
      cache_miss = cache_q[0].miss;
      void'(cache_q.pop_front());
    end else begin
      cache_hit  = 1'($urandom);
      cache_miss = 1'($urandom);
    end
    stat_sel = (fix_sel >= 0) ? IW'(fix_sel) : IW'($urandom);
    #1;
    er = '0;
    g  = -1;
    if (cyc >= m_free && v != '0) begin
      for (int i = 0; i < N; i++)
        if (g < 0 && v[(m_ptr + i) % N]) g = (m_ptr + i) % N;
      er = N'(1) << g;
    end
    chk("req_ready", 64'(req_ready), 64'(er));
    if (g >= 0) issue(g);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '1;
    look_q.delete();
    resp_q.delete();
    cache_q.delete();
    m_ptr  = 0;
    m_free = 0;
    m_gnt  = -1;
    err_at = 1 << 30;
    for (int k = 0; k < N; k++) begin
      m_hits[k] = '0;
      m_miss[k] = '0;
    end
    #1;
    chk("ready_in_reset", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst        = 1'b1;
    req_valid  = '0;
    cache_hit  = 1'b0;
    cache_miss = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_cache_valid", 64'(cache_valid), 64'd0);
    chk("rst_cache_addr", 64'(cache_addr), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    chk("rst_resp_hit", 64'(resp_hit), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_stat_hits", 64'(stat_hits), 64'd0);
    chk("rst_stat_misses", 64'(stat_misses), 64'd0);
  endtask

  // Monitor: compares every DUT output against the scoreboard each cycle.
  initial forever begin
    @(negedge clk);
    #3;
    if (rst) begin
      ev_l = (look_q.size() > 0) && (look_q[0].at == cyc);
      chk("cache_valid", 64'(cache_valid), 64'(ev_l));
      if (ev_l) begin
        chk("cache_addr", 64'(cache_addr), 64'(look_q[0].addr));
        void'(look_q.pop_front());
      end
      ev_r = (resp_q.size() > 0) && (resp_q[0].at == cyc);
      chk("resp_valid", 64'(resp_valid), 64'(ev_r));
      if (ev_r) begin
        chk("resp_id", 64'(resp_id), 64'(resp_q[0].id));
        chk("resp_hit", 64'(resp_hit), 64'(resp_q[0].hit));
        if (resp_q[0].hit) begin
          if (m_hits[resp_q[0].id] != 32'hFFFF_FFFF) m_hits[resp_q[0].id] += 1;
        end else begin
          if (m_miss[resp_q[0].id] != 32'hFFFF_FFFF) m_miss[resp_q[0].id] += 1;
        end
        void'(resp_q.pop_front());
      end
      chk("busy", 64'(busy), 64'(cyc > m_gnt && cyc < m_free));
      chk("err", 64'(err), 64'(cyc >= err_at));
      chk("stat_hits", 64'(stat_hits), 64'(m_hits[stat_sel]));
      chk("stat_misses", 64'(stat_misses), 64'(m_miss[stat_sel]));
    end
  end

  initial begin
    rst        = 1'b0;
    req_valid  = '0;
    req_addr   = '0;
    cache_hit  = 1'b0;
    cache_miss = 1'b0;
    stat_sel   = '0;
    mode       = 0;
    fix_sel    = -1;
    pending    = '0;
    for (int k = 0; k < N; k++) addr_hold[k] = 32'h1000 * (k + 1);
    do_reset();

    // single hit from requester 2
    addr_hold[2] = 32'h40;
    fix_sel = 2;
    tick(4'b0100);
    repeat (4) tick('0);

    // all requesters continuously valid, all hits
    do_reset();
    fix_sel = -1;
    for (int k = 0; k < N; k++) addr_hold[k] = $urandom;
    repeat (13) tick(4'hF);
    repeat (3) tick('0);

    // miss with stall, competing requester held off, then reset mid-stall
    mode = 1;
    tick(4'b0010);
    repeat (11) tick(4'b1000);
    repeat (5) tick(4'hF);
    do_reset();
    mode = 0;
    tick(4'hF);
    repeat (3) tick('0);

    // protocol errors: both and neither
    mode = 2;
    tick(4'b0001);
    repeat (12) tick('0);
    mode = 3;
    tick(4'b0100);
    repeat (12) tick('0);

    // saturation of hit counters
    mode = 0;
    fix_sel = 0;
    tick('0);
    force dut.hit_cnt = {N{32'hFFFF_FFFE}};
    for (int k = 0; k < N; k++) m_hits[k] = 32'hFFFF_FFFE;
    #1;
    release dut.hit_cnt;
    tick(4'b0001);
    repeat (3) tick('0);
    tick(4'b0001);
    repeat (3) tick('0);
    chk("saturated", 64'(stat_hits), 64'hFFFF_FFFF);

    // randomized traffic
    do_reset();
    fix_sel = -1;
    mode = 4;
    repeat (400) begin
      for (int k = 0; k < N; k++) begin
        if (!pending[k] && $urandom_range(0, 2) == 0) begin
          pending[k]   = 1'b1;
          addr_hold[k] = $urandom;
        end
      end
      tick(pending);
      pending &= ~req_ready;
    end
    repeat (15) tick('0);
    chk("drain_resp", 64'(resp_q.size()), 64'd0);
    chk("drain_look", 64'(look_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares the single lookup port of configurable_cache among NUM_REQ requesters (trace-replay engines or core models) using round-robin arbitration.
- Sequences each lookup: grant, issue, sample hit/miss, and an optional miss-fill stall that models memory latency.
- Returns the hit/miss outcome to the owning requester.
- Keeps per-requester saturating hit/miss counters, readable through a select port, for hit-ratio reporting.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- ADDR_W, 32, address width.
- ID_W, 2, requester id width (= clog2(NUM_REQ)).
- MISS_PENALTY, 8, stall cycles inserted after a miss (0 allowed).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  per-requester request pending
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester k at bits [k*ADDR_W +: ADDR_W]
- req_ready  out  NUM_REQ  one-hot grant, combinational
- cache_valid  out  1  lookup strobe to the cache
- cache_addr  out  ADDR_W  lookup address to the cache
- cache_hit  in  1  cache hit, valid the cycle after cache_valid
- cache_miss  in  1  cache miss, valid the cycle after cache_valid
- resp_valid  out  1  response strobe, one cycle
- resp_id  out  ID_W  requester that owns the response
- resp_hit  out  1  1 = hit, 0 = miss
- busy  out  1  state ≠ IDLE
- err  out  1  sticky protocol error
- stat_sel  in  ID_W  counter select
- stat_hits  out  32  hit count of requester stat_sel, combinational read
- stat_misses  out  32  miss count of requester stat_sel, combinational read

Behaviour:
- Reset (rst=0 at a clk edge):
  - State → IDLE; rr_ptr=0; all counters=0; err=0.
  - cache_valid=0, cache_addr=0, resp_valid=0, resp_id=0, resp_hit=0.
  - req_ready=0 while rst=0.
  - Any in-flight request is dropped with no response.
- FSM states: IDLE, LOOKUP, RESP, STALL.
- IDLE, no req_valid bit set: stay in IDLE; req_ready=0.
- IDLE, any req_valid bit set:
  - Grant g = first set bit searching upward from rr_ptr, wrapping NUM_REQ-1 → 0.
  - req_ready[g]=1 combinationally in the same cycle.
  - At the edge: latch req_addr[g] and g; rr_ptr ← (g+1) mod NUM_REQ; state → LOOKUP.
  - The requester must hold valid/addr until it sees ready; it may drop valid afterwards.
- LOOKUP: cache_valid=1 and cache_addr=latched address (both registered) for exactly one cycle; state → RESP.
- RESP: cache_valid=0; sample cache_hit and cache_miss.
  - hit=1, miss=0: next cycle resp_valid=1, resp_hit=1, resp_id=g; hit counter[g]++; state → IDLE.
  - miss=1, hit=0, MISS_PENALTY=0: same as hit but resp_hit=0; miss counter[g]++.
  - miss=1, hit=0, MISS_PENALTY>0: state → STALL with stall_cnt=MISS_PENALTY.
  - hit=miss=1, or hit=miss=0: err ← 1 (sticky until reset); handle as a miss.
- STALL:
  - stall_cnt decrements each cycle.
  - The cycle it reaches 1: next cycle resp_valid=1, resp_hit=0, resp_id=g; miss counter[g]++; state → IDLE.
  - No grants are issued during STALL.
- Latency, measured from the grant cycle T:
  - cache_valid at T+1.
  - Hit response at T+3.
  - Miss response at T+3+MISS_PENALTY.
- Throughput: the next grant may occur in the same cycle as resp_valid, giving a peak of one hit per 3 cycles.
- Only one request is outstanding at a time; there is no queueing inside the block.
- Counters are 32-bit unsigned and saturate at 0xFFFF_FFFF (no wrap).
- resp_valid is a single-cycle pulse. resp_id and resp_hit hold their values until the next response.
- cache_addr holds its last value while cache_valid=0.
- busy=1 in LOOKUP, RESP and STALL.

Test Plan:
- Reset, then only req_valid[2]=1 with addr 0x40 and the cache returning hit at T+2:
  - req_ready=0100 at T; cache_valid with cache_addr=0x40 at T+1; resp_valid, resp_id=2, resp_hit=1 at T+3.
  - stat_sel=2 gives stat_hits=1, stat_misses=0.
- All four requesters held valid continuously, all hits:
  - Grant order 0,1,2,3,0; consecutive grants 3 cycles apart; each requester's stat_hits=1 after the first four responses.
- Miss with MISS_PENALTY=8:
  - resp_valid, resp_hit=0 at T+11; no req_ready in T+1..T+10; miss counter of that requester =1.
- Cache drives hit=miss=1 in RESP:
  - err=1 and stays 1; response has resp_hit=0; miss counter increments.
  - Cache drives hit=miss=0 in RESP: same result.
- rst=0 asserted during STALL:
  - Next cycle state=IDLE, busy=0, no resp_valid, counters=0, err=0.
  - After rst=1 the first grant goes to requester 0 when all requesters are valid.
- Counter preloaded to 0xFFFF_FFFE via force, then 2 hits:
  - stat_hits=0xFFFF_FFFF after each hit; no wrap to 0.
